// File: rtl/nzcv_status_unit_if.sv
// nzcv_status_unit_if: upstream-to-status-unit bundle; the master drives the
// flag sources and exception strobes, the slave returns the flag state.
interface nzcv_status_unit_if #(parameter int PTR_W = 3);
    logic [3:0]       alu_flags;
    logic             s_bit;
    logic             cond_pass;
    logic             msr_we;
    logic [3:0]       msr_data;
    logic             stall;
    logic             exc_entry;
    logic             exc_return;
    logic [3:0]       flags;
    logic [3:0]       flags_fwd;
    logic [PTR_W-1:0] depth;
    logic             busy;
    logic             stack_err;

    modport master (
        output alu_flags, s_bit, cond_pass, msr_we, msr_data, stall, exc_entry, exc_return,
        input  flags, flags_fwd, depth, busy, stack_err
    );
    modport slave (
        input  alu_flags, s_bit, cond_pass, msr_we, msr_data, stall, exc_entry, exc_return,
        output flags, flags_fwd, depth, busy, stack_err
    );
endinterface

// File: rtl/nzcv_status_unit.sv
// nzcv_status_unit: architectural NZCV flags with a LIFO saved-flags stack for exceptions.
// Optional macro FLAG_FWD_EN makes flags_fwd show next-edge flags combinationally.
module nzcv_status_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int PTR_W       = 3
) (
    input logic               clk,
    input logic               reset_n,
    nzcv_status_unit_if.slave bus
);
    localparam logic [1:0] IDLE          = 2'd0;
    localparam logic [1:0] ENTRY_FLUSH   = 2'd1;
    localparam logic [1:0] RETURN_SETTLE = 2'd2;
    localparam logic [PTR_W-1:0] FULL    = PTR_W'(STACK_DEPTH);

    logic [1:0]       state, state_nxt;
    logic [3:0]       flags, flags_nxt, top;
    logic [PTR_W-1:0] depth;
    logic             busy, stack_err;
    logic [3:0]       stack [2**PTR_W];
    logic             live, do_ret, do_ent, wr_ok, can_push, can_pop;

    // Return beats entry; both beat flag writes, which are flushed that cycle.
    always_comb begin
        live      = ~bus.stall & (state == IDLE);
        do_ret    = live & bus.exc_return;
        do_ent    = live & bus.exc_entry & ~bus.exc_return;
        wr_ok     = live & ~bus.exc_return & ~bus.exc_entry;
        can_push  = depth < FULL;
        can_pop   = depth != '0;
        top       = stack[depth - 1'b1];
        flags_nxt = (do_ret & can_pop)                  ? top :
                    (wr_ok & bus.msr_we)                ? bus.msr_data :
                    (wr_ok & bus.s_bit & bus.cond_pass) ? bus.alu_flags : flags;
        state_nxt = bus.stall ? state :
                    do_ret    ? RETURN_SETTLE :
                    do_ent    ? ENTRY_FLUSH : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            flags     <= 4'b0000;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= state_nxt != IDLE;
            flags     <= flags_nxt;
            stack_err <= stack_err | (do_ent & ~can_push) | (do_ret & ~can_pop);
            if (do_ent && can_push)
                depth <= depth + 1'b1;
            else if (do_ret && can_pop)
                depth <= depth - 1'b1;
        end
    end

    // Stack contents need no reset; depth alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_ent && can_push)
            stack[depth] <= flags;
    end

    assign bus.flags     = flags;
    assign bus.depth     = depth;
    assign bus.busy      = busy;
    assign bus.stack_err = stack_err;
`ifdef FLAG_FWD_EN
    assign bus.flags_fwd = flags_nxt;
`else
    assign bus.flags_fwd = flags;
`endif
endmodule

// File: doc/nzcv_status_unit.md
Name: nzcv_status_unit

Overview:
- Holds the architectural NZCV condition flags and feeds them to the condition-code evaluator.
- Updates the flags from ALU results on S-bit instructions whose condition passed, or from MSR flag writes.
- Saves and restores the flags across exceptions through a small saved-flags stack.
- Sits between the ALU/decode stage and the condition evaluator. Also drives a flag-forwarding output for back-to-back flag-setting/conditional instructions.

Parameters:
STACK_DEPTH, 4, number of saved-flag entries; nested-exception depth (must be >= 1).
PTR_W, 3, width of the stack occupancy counter; must hold 0..STACK_DEPTH.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
alu_flags  input  4  ALU result flags: [0]=N, [1]=Z, [2]=C, [3]=V
s_bit  input  1  current instruction sets flags
cond_pass  input  1  condition-evaluator result for the current instruction
msr_we  input  1  MSR flag-field write strobe
msr_data  input  4  MSR flag value, same bit order as alu_flags
stall  input  1  pipeline stall; blocks all state changes
exc_entry  input  1  exception taken this cycle (one-cycle pulse)
exc_return  input  1  exception return this cycle (one-cycle pulse)
flags  output  4  registered architectural flags, same bit order
flags_fwd  output  4  forwarded flags (see Optional Feature)
depth  output  PTR_W  current saved-stack occupancy
busy  output  1  1 while FSM is not in IDLE; upstream must not issue S-bit ops
stack_err  output  1  sticky: push when full or pop when empty

Behaviour:
- Reset (async, reset_n=0):
  - flags=4'b0000, depth=0, stack_err=0, busy=0, FSM=IDLE.
  - Stack contents are don't-care.
- Write-enable priority per cycle, highest first: stall, then exc_return, then exc_entry, then msr_we, then ALU update (s_bit & cond_pass).
- stall=1: no register, stack, counter or FSM changes; all inputs ignored.
- ALU update: flags <= alu_flags on the next edge (1-cycle latency). No update if cond_pass=0 or s_bit=0.
- MSR: flags <= msr_data on the next edge. It overrides a simultaneous ALU update.
- FSM states: IDLE, ENTRY_FLUSH, RETURN_SETTLE.
  - IDLE + exc_entry (depth<STACK_DEPTH): push current registered flags (pre-update value); depth+1; flags unchanged; ALU/MSR writes that cycle dropped (instruction flushed). Go to ENTRY_FLUSH.
  - IDLE + exc_entry (depth==STACK_DEPTH): no push; stack_err<=1; flags unchanged; still go to ENTRY_FLUSH.
  - ENTRY_FLUSH: one cycle, busy=1, ALU/MSR writes ignored. Go to IDLE.
  - IDLE + exc_return (depth>0): pop top entry into flags; depth-1; ALU/MSR writes dropped. Go to RETURN_SETTLE.
  - IDLE + exc_return (depth==0): flags unchanged; stack_err<=1. Go to RETURN_SETTLE.
  - RETURN_SETTLE: one cycle, busy=1, ALU/MSR writes ignored. Go to IDLE.
  - exc_entry and exc_return asserted together: return wins; entry is discarded.
  - exc_entry/exc_return while busy=1: ignored (no push/pop, no error).
- busy is registered; it is 1 exactly in ENTRY_FLUSH and RETURN_SETTLE.
- Stack is LIFO. Pointer does not wrap: push at full and pop at empty are both blocked.
- stack_err clears only on reset.
- Reset mid-sequence: immediate return to reset values; saved entries are lost (depth=0).

Optional Feature:
Macro FLAG_FWD_EN.
- Defined: flags_fwd is combinational and shows the value flags will take at the next edge under the priority rules above (popped entry, msr_data, alu_flags, or flags). With stall=1 or busy=1 it equals flags.
- Undefined: flags_fwd = flags (pure registered copy, no combinational path from alu_flags/msr_data).

Test Plan:
1. Reset released, alu_flags=4'b1010, s_bit=1, cond_pass=1 -> flags=4'b1010 one cycle later; with cond_pass=0 instead -> flags stays 4'b0000.
2. Same cycle: msr_we=1, msr_data=4'b0110 plus ALU update 4'b1111 -> flags=4'b0110.
3. flags=4'b0011; exc_entry pulse with an ALU update of 4'b1000 -> depth=1, flags=4'b0011, busy=1 for one cycle. Then MSR 4'b1100, then exc_return -> flags=4'b0011, depth=0.
4. Five exc_entry pulses with STACK_DEPTH=4, spaced past busy -> depth=4, stack_err=1 after the fifth. Four exc_return pulses restore entries in LIFO order. A fifth return leaves flags unchanged.
5. stall=1 with ALU update 4'b1111 and exc_entry -> no change to flags/depth/FSM. Deassert stall -> normal operation resumes.
6. With FLAG_FWD_EN: alu_flags=4'b0101, s_bit=1, cond_pass=1 -> flags_fwd=4'b0101 in the same cycle, flags=4'b0101 the next cycle. Without the macro -> flags_fwd follows flags.
